// File: rtl/board_vga_renderer.sv
// 2048 board renderer: 640x480@60 VGA timing from a clk/2 pixel enable, board drawn from a per-frame snapshot.
// Optional DEFEAT_OVERLAY_EN: darken the board region with a red tint while the defeat snapshot is set.
module board_vga_renderer #(
   parameter int TILE_PX   = 100,
   parameter int BORDER_PX = 4,
   parameter int X0        = 120,
   parameter int Y0        = 40,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] matrix [0:3][0:3],
   input  logic       defeat,
   output logic       vga_clk,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue
);
   localparam int OW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] X_START  = 10'(X0);
   localparam logic [9:0] Y_START  = 10'(Y0);
   localparam logic [OW-1:0] OFF_LAST = OW'(TILE_PX - 1);
   localparam logic [OW-1:0] B_LO     = OW'(BORDER_PX);
   localparam logic [OW-1:0] B_HI     = OW'(TILE_PX - BORDER_PX);

   function automatic logic [23:0] palette(input logic [3:0] e);
      case (e)
         4'd0:    palette = 24'hCDC1B4;
         4'd1:    palette = 24'hEEE4DA;
         4'd2:    palette = 24'hEDE0C8;
         4'd3:    palette = 24'hF2B179;
         4'd4:    palette = 24'hF59563;
         4'd5:    palette = 24'hF67C5F;
         4'd6:    palette = 24'hF65E3B;
         4'd7:    palette = 24'hEDCF72;
         4'd8:    palette = 24'hEDCC61;
         4'd9:    palette = 24'hEDC850;
         4'd10:   palette = 24'hEDC53F;
         default: palette = 24'hEDC22E;
      endcase
   endfunction

   logic          pe_q, pe_d;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
   logic [1:0]    col_q, col_d, row_q, row_d;
   logic          inx_q, inx_d, iny_q, iny_d;
   logic [3:0]    snap_q [0:3][0:3];
   logic [3:0]    snap_d [0:3][0:3];
   logic          sdef_q, sdef_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          visible, border;
   logic [23:0]   tile_rgb, pix_rgb;

   always_comb begin
      pe_d    = ~pe_q;
      h_d     = h_q;
      v_d     = v_q;
      ox_d    = ox_q;
      col_d   = col_q;
      inx_d   = inx_q;
      oy_d    = oy_q;
      row_d   = row_q;
      iny_d   = iny_q;
      snap_d  = snap_q;
      sdef_d  = sdef_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      blank_d = blank_q;
      rgb_d   = rgb_q;

      visible  = (h_q < H_VIS) && (v_q < V_VIS);
      border   = (ox_q < B_LO) || (ox_q >= B_HI) || (oy_q < B_LO) || (oy_q >= B_HI);
      tile_rgb = border ? 24'hBBADA0 : palette(snap_q[row_q][col_q]);
`ifdef DEFEAT_OVERLAY_EN
      if (sdef_q)
         tile_rgb = {(tile_rgb[23:16] >> 1) | 8'h80, tile_rgb[15:8] >> 1, tile_rgb[7:0] >> 1};
`endif
      if (!visible)
         pix_rgb = 24'h000000;
      else if (!(inx_q && iny_q))
         pix_rgb = 24'h202020;
      else
         pix_rgb = tile_rgb;

      if (pe_q) begin
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
         // Sub-tile trackers follow h/v so tile index and offset need no dividers.
         if (h_d == X_START) begin
            inx_d = 1'b1;
            ox_d  = '0;
            col_d = 2'd0;
         end else if (inx_q) begin
            if (ox_q == OFF_LAST) begin
               ox_d  = '0;
               col_d = col_q + 2'd1;
               inx_d = (col_q != 2'd3);
            end else begin
               ox_d = ox_q + OW'(1);
            end
         end
         if (h_q == H_LAST) begin
            if (v_d == Y_START) begin
               iny_d = 1'b1;
               oy_d  = '0;
               row_d = 2'd0;
            end else if (iny_q) begin
               if (oy_q == OFF_LAST) begin
                  oy_d  = '0;
                  row_d = row_q + 2'd1;
                  iny_d = (row_q != 2'd3);
               end else begin
                  oy_d = oy_q + OW'(1);
               end
            end
         end
         if (h_q == 10'd0 && v_q == V_VIS) begin
            snap_d = matrix;
            sdef_d = defeat;
         end
         hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
         vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
         blank_d = visible;
         rgb_d   = pix_rgb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pe_q    <= 1'b0;
         h_q     <= 10'd0;
         v_q     <= 10'd0;
         ox_q    <= '0;
         col_q   <= 2'd0;
         inx_q   <= (X_START == 10'd0);
         oy_q    <= '0;
         row_q   <= 2'd0;
         iny_q   <= (Y_START == 10'd0);
         snap_q  <= '{default: 4'h0};
         sdef_q  <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b0;
         rgb_q   <= 24'h000000;
      end else begin
         pe_q    <= pe_d;
         h_q     <= h_d;
         v_q     <= v_d;
         ox_q    <= ox_d;
         col_q   <= col_d;
         inx_q   <= inx_d;
         oy_q    <= oy_d;
         row_q   <= row_d;
         iny_q   <= iny_d;
         snap_q  <= snap_d;
         sdef_q  <= sdef_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= blank_d;
         rgb_q   <= rgb_d;
      end
   end

`ifndef DEFEAT_OVERLAY_EN
   logic unused_sdef;
   assign unused_sdef = sdef_q;
`endif

   assign vga_clk = pe_q;
   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign blank_n = blank_q;
   assign sync_n  = 1'b0;
   assign red     = rgb_q[23:16];
   assign green   = rgb_q[15:8];
   assign blue    = rgb_q[7:0];
endmodule

// File: tb/tb_board_vga_renderer.sv
// Scoreboard bench for board_vga_renderer on a shrunken raster; reference pixels come from raster/tile arithmetic.
module tb_board_vga_renderer;
   localparam int TP = 10, BP = 2, XO = 12, YO = 4;
   localparam int HA = 64, HF = 4, HS = 8, HB = 8, HT = HA + HF + HS + HB;
   localparam int VA = 48, VF = 3, VS = 2, VB = 3, VT = VA + VF + VS + VB;
   localparam logic [23:0] PAL [16] = '{24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179,
                                        24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
                                        24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E,
                                        24'hEDC22E, 24'hEDC22E, 24'hEDC22E, 24'hEDC22E};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] matrix [0:3][0:3];
   logic       defeat = 1'b0;
   logic       vga_clk, hsync, vsync, blank_n, sync_n;
   logic [7:0] red, green, blue;

   always #10 clk = ~clk;

   board_vga_renderer #(
      .TILE_PX(TP), .BORDER_PX(BP), .X0(XO), .Y0(YO),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .reset(reset), .matrix(matrix), .defeat(defeat),
      .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n),
      .red(red), .green(green), .blue(blue)
   );

   typedef struct {
      int          h;
      int          v;
      logic        hs;
      logic        vs;
      logic        bl;
      logic [23:0] rgb;
      logic        ovl;
   } pix_t;

   pix_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] m_snap [0:3][0:3];
   logic       m_sdef;
   int         m_h, m_v;
   bit         m_ph;

   function automatic logic [23:0] ref_rgb(input int h, input int v);
      logic [23:0] c;
      int ox, oy, r, k;
      if (h >= HA || v >= VA) return 24'h000000;
      if (h < XO || h >= XO + 4 * TP || v < YO || v >= YO + 4 * TP) return 24'h202020;
      ox = (h - XO) % TP;
      oy = (v - YO) % TP;
      k  = (h - XO) / TP;
      r  = (v - YO) / TP;
      if (ox < BP || ox >= TP - BP || oy < BP || oy >= TP - BP)
         c = 24'hBBADA0;
      else
         c = PAL[m_snap[r][k]];
`ifdef DEFEAT_OVERLAY_EN
      if (m_sdef) c = {(c[23:16] >> 1) | 8'h80, c[15:8] >> 1, c[7:0] >> 1};
`endif
      return c;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Reference model: one pixel per two clocks, raster order, snapshot at the start of vblank.
   initial begin
      pix_t e;
      forever begin
         @(posedge clk);
         if (reset) begin
            exp_q.delete();
            m_h = 0; m_v = 0; m_ph = 1'b0;
            m_snap = '{default: 4'h0};
            m_sdef = 1'b0;
            e.h = -1; e.v = -1; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.rgb = 24'h0; e.ovl = 1'b0;
            exp_q.push_back(e);
         end else begin
            if (m_ph) begin
               e.h   = m_h;
               e.v   = m_v;
               e.hs  = !(m_h >= HA + HF && m_h < HA + HF + HS);
               e.vs  = !(m_v >= VA + VF && m_v < VA + VF + VS);
               e.bl  = (m_h < HA) && (m_v < VA);
               e.rgb = ref_rgb(m_h, m_v);
               e.ovl = m_sdef;
               exp_q.push_back(e);
               if (m_h == 0 && m_v == VA) begin
                  m_snap = matrix;
                  m_sdef = defeat;
               end
               m_h++;
               if (m_h == HT) begin
                  m_h = 0;
                  m_v++;
                  if (m_v == VT) m_v = 0;
               end
            end
            m_ph = !m_ph;
         end
      end
   end

   int hlow, vlow, blank_cnt, pix_idx, last_hf, last_vf;
   bit hf_ok, vf_ok, prev_hs, prev_vs;

   // Monitor: a pixel is presented while vga_clk is high.
   initial begin
      pix_t e;
      logic [23:0] got;
      hlow = 0; vlow = 0; blank_cnt = 0; pix_idx = 0; last_hf = 0; last_vf = 0;
      hf_ok = 0; vf_ok = 0; prev_hs = 1; prev_vs = 1;
      forever begin
         @(negedge clk);
         if (vga_clk === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty: pixel presented with no expected entry");
            end else begin
               e   = exp_q.pop_front();
               got = {red, green, blue};
               checks++;
               if ({hsync, vsync, blank_n, sync_n, got} !== {e.hs, e.vs, e.bl, 1'b0, e.rgb}) begin
                  errors++;
                  if (errors <= 20)
                     $display("FAIL pixel h=%0d v=%0d: got hs=%b vs=%b bl=%b sn=%b rgb=%h, expected hs=%b vs=%b bl=%b sn=0 rgb=%h (ovl=%b)",
                              e.h, e.v, hsync, vsync, blank_n, sync_n, got, e.hs, e.vs, e.bl, e.rgb, e.ovl);
               end
               if (e.h < 0) begin
                  hf_ok = 0; vf_ok = 0; hlow = 0; vlow = 0; blank_cnt = 0; pix_idx = 0;
                  prev_hs = 1; prev_vs = 1;
               end else begin
                  pix_idx++;
                  if (blank_n === 1'b1) blank_cnt++;
                  if (hsync === 1'b0 && prev_hs) begin
                     if (hf_ok) chk("hsync_period", pix_idx - last_hf, HT);
                     last_hf = pix_idx; hf_ok = 1; hlow = 0;
                  end
                  if (hsync === 1'b1 && !prev_hs && hf_ok) chk("hsync_low_width", hlow, HS);
                  if (hsync === 1'b0) hlow++;
                  if (vsync === 1'b0 && prev_vs) begin
                     if (vf_ok) begin
                        chk("vsync_period", pix_idx - last_vf, VT * HT);
                        chk("blank_n_visible_count", blank_cnt, HA * VA);
                     end
                     last_vf = pix_idx; vf_ok = 1; vlow = 0; blank_cnt = 0;
                  end
                  if (vsync === 1'b1 && !prev_vs && vf_ok) chk("vsync_low_width", vlow, VS * HT);
                  if (vsync === 1'b0) vlow++;
                  prev_hs = hsync;
                  prev_vs = vsync;
               end
            end
         end
      end
   end

   // Wait for the negedge just before the pixel-enable edge that renders (h,v).
   task automatic wait_pix(input int v, input int h);
      int n;
      n = 0;
      while (!(m_v == v && m_h == h && m_ph)) begin
         @(negedge clk);
         n++;
         if (n > 25000) begin
            checks++;
            errors++;
            $display("FAIL wait_pix_timeout: never reached v=%0d h=%0d, now v=%0d h=%0d", v, h, m_v, m_h);
            break;
         end
      end
   endtask

   task automatic rand_matrix();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            matrix[r][k] = 4'($urandom_range(0, 15));
   endtask

   initial begin
      matrix = '{default: 4'h0};
      reset  = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Frame 0 renders the empty board; this change lands in frame 1 only.
      wait_pix(20, 30);
      matrix[2][3] = 4'd11;
      wait_pix(VA + 1, 0);

      // Frame 1 shows tile [2][3]; frame 2 gets a single 1 at [0][0].
      wait_pix(VA - 1, 10);
      matrix = '{default: 4'h0};
      matrix[0][0] = 4'd1;
      wait_pix(VA + 1, 0);

      // Mid-frame change inside tile row 0 must not tear frame 2.
      wait_pix(YO + 5, 20);
      matrix[0][0] = 4'd2;
      wait_pix(VA + 1, 0);

      // Frame 3: random updates, defeat raised, and a change on the snapshot cycle itself.
      wait_pix($urandom_range(0, 15), $urandom_range(0, HT - 1));
      rand_matrix();
      wait_pix($urandom_range(16, 31), $urandom_range(0, HT - 1));
      rand_matrix();
      defeat = 1'b1;
      wait_pix($urandom_range(32, VA - 2), $urandom_range(0, HT - 1));
      rand_matrix();
      wait_pix(VA, 0);
      rand_matrix();

      // Frame 4 (overlay when enabled), then a one-cycle reset in mid-frame.
      wait_pix(30, 40);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rand_matrix();

      // Restarted frame draws an empty snapshot; the following one uses the captured state.
      wait_pix(VA + 1, 0);
      wait_pix(YO + 4 * TP, 0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
